// File: rtl/mux_scan_ctrl.sv
//==============================================================================
// Module : mux_scan_ctrl
// Round-robin select sequencer for a 4:1 mux. It dwells on each enabled channel,
// captures the mux output, and publishes a coherent 4-bit frame with a done pulse.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module mux_scan_ctrl #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         ch_mask,
    input  logic               mux_out,
    output logic [1:0]         ss,
    output logic [3:0]         sample,
    output logic               frame_done,
    output logic               busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ss_q, ss_d;
    logic [3:0]         sample_q, sample_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [3:0]         shadow_q, shadow_d;
    logic [3:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic [3:0]         w_hi_mask;
    logic [1:0]         w_next_ss;
    logic [1:0]         w_first_ss;

    function automatic logic [1:0] lowest_bit(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Enabled channels strictly above the current select.
    assign w_hi_mask  = mask_q & (4'b1110 << ss_q);
    assign w_next_ss  = lowest_bit(w_hi_mask);
    assign w_first_ss = lowest_bit(ch_mask);

    always_comb begin
        state_d      = state_q;
        ss_d         = ss_q;
        sample_d     = sample_q;
        frame_done_d = 1'b0;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        mask_d       = mask_q;
        dwell_d      = dwell_q;

        case (state_q)
            S_IDLE: begin
                if (en && (ch_mask != 4'd0)) begin
                    mask_d   = ch_mask;
                    dwell_d  = dwell;
                    ss_d     = w_first_ss;
                    cnt_d    = '0;
                    shadow_d = 4'd0;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cnt_q != dwell_q) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d          = '0;
                    shadow_d[ss_q] = mux_out;
                    if (w_hi_mask != 4'd0) begin
                        ss_d = w_next_ss;
                    end else begin
                        // Frame boundary: publish, then either restart or stop.
                        sample_d     = shadow_d & mask_q;
                        frame_done_d = 1'b1;
                        if (en && (ch_mask != 4'd0)) begin
                            mask_d   = ch_mask;
                            dwell_d  = dwell;
                            ss_d     = w_first_ss;
                            shadow_d = 4'd0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_SCAN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ss_q         <= 2'd0;
            sample_q     <= 4'd0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            shadow_q     <= 4'd0;
            mask_q       <= 4'd0;
            dwell_q      <= '0;
        end else begin
            state_q      <= state_d;
            ss_q         <= ss_d;
            sample_q     <= sample_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            mask_q       <= mask_d;
            dwell_q      <= dwell_d;
        end
    end

    assign ss         = ss_q;
    assign sample     = sample_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
//==============================================================================
// Module : tb_mux_scan_ctrl
// Bench for mux_scan_ctrl: directed scenarios followed by random stimulus,
// compared cycle by cycle against a frame-position reference model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [3:0] ch_mask = 4'd0;
    logic [3:0] data = 4'd0;
    logic       mux_out;
    logic [1:0] ss;
    logic [3:0] sample;
    logic       frame_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    assign mux_out = data[ss];

    always #5 clk = ~clk;

    mux_scan_ctrl #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dwell      (dwell),
        .ch_mask    (ch_mask),
        .mux_out    (mux_out),
        .ss         (ss),
        .sample     (sample),
        .frame_done (frame_done),
        .busy       (busy)
    );

    // Reference model: a frame is a list of channels, each held for (d+1)
    // cycles; position within the frame determines select and capture points.
    int       m_list[4];
    int       m_n;
    int       m_d;
    int       m_pos;
    bit       m_busy;
    bit [1:0] m_ss;
    bit [3:0] m_sample;
    bit [3:0] m_shadow;
    bit       m_done;

    task automatic m_start();
        m_n = 0;
        for (int i = 0; i < 4; i++) begin
            if (ch_mask[i]) begin
                m_list[m_n] = i;
                m_n++;
            end
        end
        m_d      = int'(dwell);
        m_pos    = 0;
        m_shadow = 4'd0;
        m_ss     = 2'(m_list[0]);
        m_busy   = 1'b1;
    endtask

    task automatic m_step();
        int k;
        if (rst) begin
            m_busy = 0; m_ss = 0; m_sample = 0; m_shadow = 0; m_done = 0; m_pos = 0;
        end else if (!m_busy) begin
            m_done = 0;
            if (en && ch_mask != 4'd0) m_start();
        end else begin
            m_done = 0;
            k = m_pos / (m_d + 1);
            if (m_pos % (m_d + 1) == m_d) begin
                m_shadow[m_list[k]] = data[m_list[k]];
            end
            if (m_pos == m_n * (m_d + 1) - 1) begin
                m_sample = m_shadow;
                m_done   = 1;
                if (en && ch_mask != 4'd0) m_start();
                else m_busy = 0;
            end else begin
                m_pos++;
                m_ss = 2'(m_list[m_pos / (m_d + 1)]);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        chk("ss", 8'(ss), 8'(m_ss));
        chk("sample", 8'(sample), 8'(m_sample));
        chk("frame_done", 8'(frame_done), 8'(m_done));
        chk("busy", 8'(busy), 8'(m_busy));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int dones;

    initial begin
        m_busy = 0; m_ss = 0; m_sample = 0; m_shadow = 0; m_done = 0;
        m_pos = 0; m_n = 1; m_d = 0;
        for (int i = 0; i < 4; i++) m_list[i] = 0;

        // Reset state
        rst = 1; run(2);
        rst = 0;

        // All four channels, one cycle each
        en = 1; ch_mask = 4'b1111; dwell = 8'd0; data = 4'b1010;
        run(14);
        chk("t2_sample", 8'(sample), 8'h0A);

        // Reset held for three cycles mid-scan
        rst = 1; run(3);
        rst = 0;
        chk("t1_sample_after_rst", 8'(sample), 8'h00);

        // Sparse mask with dwell
        ch_mask = 4'b0101; dwell = 8'd2; data = 4'b1111;
        run(20);
        chk("t3_sample", 8'(sample), 8'h05);

        // Drop enable early in a full frame
        en = 0; run(8);
        en = 1; ch_mask = 4'b1111; dwell = 8'd0; data = 4'b0110;
        run(2);
        en = 0;
        run(6);
        chk("t4_ss_hold", 8'(ss), 8'h03);
        chk("t4_idle", 8'(busy), 8'h00);

        // Mask change mid-frame takes effect at the next frame
        en = 1; ch_mask = 4'b1111; dwell = 8'd1; data = 4'b1101;
        run(3);
        ch_mask = 4'b0010;
        run(16);

        // Enable with empty mask
        en = 0; run(6);
        en = 1; ch_mask = 4'b0000;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (frame_done) dones++;
        end
        chk("t6_no_done", 8'(dones), 8'h00);

        // Single channel, maximum dwell
        ch_mask = 4'b1000; dwell = 8'hFF; data = 4'b1000;
        run(530);
        chk("max_dwell_sample", 8'(sample), 8'h08);

        // Random stimulus
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 8) en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 10) ch_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 10) dwell = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 30) data = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
